spdif_receive: RTL and testbench

Biphase-mark S/PDIF receiver: the decode-side counterpart of `spdif_transmit`. It oversamples an incoming S/PDIF line on a single system clock, measures intervals between line transitions, and recognises B/M/W preambles. It decodes the 28 data slots of each subframe, checks parity, and presents matched left/right 24-bit sample pairs with a one-cycle strobe. The block feeds the sample FIFO when the design runs with S/PDIF as its source.

---
 rtl/spdif_receive.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_spdif_receive.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_receive.sv
// ---------------------------------------------------------------------------
// spdif_receive
//
// Biphase-mark S/PDIF receiver. The incoming line is oversampled on clk. The
// block measures the time between line transitions, recognises the B/M/W
// preambles and decodes the 28 data slots of each subframe. It checks even
// parity and pairs a channel A subframe with the following channel B
// subframe. Each completed pair is presented with a single-cycle strobe.
//
// Parameters
//   CELL_CYCLES  clk cycles per biphase half-cell (UI), >= 4
//   SYNC_FRAMES  consecutive good pairs required before locked rises
//
// Ports
//   clk           in   oversampling clock
//   rst           in   asynchronous, active-high reset
//   spdif_in      in   S/PDIF line (asynchronous to clk)
//   data_left     out  channel A audio, slots 4..27, LSB = slot 4
//   data_right    out  channel B audio, same format
//   validity      out  OR of the two V bits of the emitted pair
//   block_start   out  emitted pair's left subframe carried a B preamble
//   sample_valid  out  one-cycle strobe, new pair on the data outputs
//   parity_error  out  one-cycle strobe on a subframe parity failure
//   locked        out  receiver synchronised
// ---------------------------------------------------------------------------
module spdif_receive #(
    parameter int CELL_CYCLES = 4,
    parameter int SYNC_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spdif_in,
    output logic [23:0] data_left,
    output logic [23:0] data_right,
    output logic        validity,
    output logic        block_start,
    output logic        sample_valid,
    output logic        parity_error,
    output logic        locked
);

    localparam int CNT_MAX = 4 * CELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GOOD_W  = (SYNC_FRAMES < 1) ? 1 : $clog2(SYNC_FRAMES + 1);

    // Interval classification limits (inclusive upper bounds, in clk cycles)
    localparam logic [CNT_W-1:0] LIM_S   = CNT_W'((3 * CELL_CYCLES) / 2);
    localparam logic [CNT_W-1:0] LIM_M   = CNT_W'((5 * CELL_CYCLES) / 2);
    localparam logic [CNT_W-1:0] LIM_G   = CNT_W'((7 * CELL_CYCLES) / 2);
    localparam logic [CNT_W-1:0] LIM_MAX = CNT_W'(CNT_MAX);

    localparam logic [GOOD_W-1:0] GOOD_LIM = GOOD_W'(SYNC_FRAMES);

    typedef enum logic [1:0] {
        HUNT,
        PRE,
        DATA
    } state_t;

    typedef enum logic [1:0] {
        CL_S,
        CL_M,
        CL_G,
        CL_BAD
    } cls_t;

    function automatic cls_t classify(input logic [CNT_W-1:0] len);
        cls_t c;
        if (len <= LIM_S) begin
            c = CL_S;
        end else if (len <= LIM_M) begin
            c = CL_M;
        end else if (len <= LIM_G) begin
            c = CL_G;
        end else begin
            c = CL_BAD;
        end
        return c;
    endfunction

    function automatic logic [GOOD_W-1:0] sat_inc(input logic [GOOD_W-1:0] v);
        logic [GOOD_W-1:0] r;
        if (v >= GOOD_LIM) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser, p2: edge-detect history ----
    logic sync_p0;
    logic sync_p1;
    logic prev_p2;
    logic edge_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= spdif_in;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    // Either polarity of transition counts as an edge.
    assign edge_det = sync_p1 ^ prev_p2;

    // ---- interval counter: cycles since the last edge, saturating ----
    logic [CNT_W-1:0] ivl_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_cnt <= '0;
        end else if (edge_det) begin
            ivl_cnt <= CNT_W'(1);
        end else if (ivl_cnt != LIM_MAX) begin
            ivl_cnt <= ivl_cnt + 1'b1;
        end
    end

    cls_t cls;
    logic timeout;

    assign cls     = classify(ivl_cnt);
    assign timeout = (ivl_cnt == LIM_MAX) && !edge_det;

    // ---- decoder FSM ----
    state_t      state, state_n;
    logic        need_g, need_g_n;     // PRE still waits for the opening G
    logic [1:0]  pre_cnt, pre_cnt_n;
    cls_t        pre_c0, pre_c0_n;
    cls_t        pre_c1, pre_c1_n;
    logic        chan_b, chan_b_n;
    logic        blk, blk_n;
    logic        half, half_n;         // first short of a '1' cell seen
    logic [4:0]  slot, slot_n;
    logic        par, par_n;
    logic [24:0] sub, sub_n;           // slots 4..28, LSB = slot 4

    logic err;
    logic par_fail;
    logic sf_done;
    logic bit_fire;
    logic bit_val;
    logic pre_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HUNT;
            need_g  <= 1'b0;
            pre_cnt <= 2'd0;
            pre_c0  <= CL_S;
            pre_c1  <= CL_S;
            chan_b  <= 1'b0;
            blk     <= 1'b0;
            half    <= 1'b0;
            slot    <= 5'd0;
            par     <= 1'b0;
            sub     <= '0;
        end else begin
            state   <= state_n;
            need_g  <= need_g_n;
            pre_cnt <= pre_cnt_n;
            pre_c0  <= pre_c0_n;
            pre_c1  <= pre_c1_n;
            chan_b  <= chan_b_n;
            blk     <= blk_n;
            half    <= half_n;
            slot    <= slot_n;
            par     <= par_n;
            sub     <= sub_n;
        end
    end

    always_comb begin
        state_n   = state;
        need_g_n  = need_g;
        pre_cnt_n = pre_cnt;
        pre_c0_n  = pre_c0;
        pre_c1_n  = pre_c1;
        chan_b_n  = chan_b;
        blk_n     = blk;
        half_n    = half;
        slot_n    = slot;
        par_n     = par;
        sub_n     = sub;
        err       = 1'b0;
        par_fail  = 1'b0;
        sf_done   = 1'b0;
        bit_fire  = 1'b0;
        bit_val   = 1'b0;
        pre_ok    = 1'b0;

        case (state)
            HUNT: begin
                if (edge_det && cls == CL_G) begin
                    state_n   = PRE;
                    need_g_n  = 1'b0;
                    pre_cnt_n = 2'd0;
                end
            end

            PRE: begin
                if (timeout) begin
                    err = 1'b1;
                end else if (edge_det) begin
                    if (cls == CL_BAD) begin
                        err = 1'b1;
                    end else if (need_g) begin
                        // Coming out of DATA, the next preamble must open with a G.
                        if (cls == CL_G) begin
                            need_g_n = 1'b0;
                        end else begin
                            err = 1'b1;
                        end
                    end else begin
                        case (pre_cnt)
                            2'd0: begin
                                pre_c0_n  = cls;
                                pre_cnt_n = 2'd1;
                            end
                            2'd1: begin
                                pre_c1_n  = cls;
                                pre_cnt_n = 2'd2;
                            end
                            default: begin
                                if (pre_c0 == CL_S && pre_c1 == CL_S && cls == CL_G) begin
                                    chan_b_n = 1'b0;
                                    blk_n    = 1'b1;
                                    pre_ok   = 1'b1;
                                end else if (pre_c0 == CL_G && pre_c1 == CL_S && cls == CL_S) begin
                                    chan_b_n = 1'b0;
                                    blk_n    = 1'b0;
                                    pre_ok   = 1'b1;
                                end else if (pre_c0 == CL_M && pre_c1 == CL_S && cls == CL_M) begin
                                    chan_b_n = 1'b1;
                                    blk_n    = 1'b0;
                                    pre_ok   = 1'b1;
                                end else begin
                                    err = 1'b1;
                                end
                                if (pre_ok) begin
                                    state_n   = DATA;
                                    slot_n    = 5'd4;
                                    par_n     = 1'b0;
                                    half_n    = 1'b0;
                                    pre_cnt_n = 2'd0;
                                end
                            end
                        endcase
                    end
                end
            end

            DATA: begin
                if (timeout) begin
                    err = 1'b1;
                end else if (edge_det) begin
                    case (cls)
                        CL_M: begin
                            if (half) begin
                                err = 1'b1;
                            end else begin
                                bit_fire = 1'b1;
                                bit_val  = 1'b0;
                            end
                        end
                        CL_S: begin
                            if (half) begin
                                bit_fire = 1'b1;
                                bit_val  = 1'b1;
                                half_n   = 1'b0;
                            end else begin
                                half_n = 1'b1;
                            end
                        end
                        default: err = 1'b1;
                    endcase
                end

                if (bit_fire) begin
                    // Only slots 4..28 (audio + V) need to be retained.
                    if (slot <= 5'd28) begin
                        sub_n = {bit_val, sub[24:1]};
                    end
                    par_n  = par ^ bit_val;
                    slot_n = slot + 5'd1;
                    if (slot == 5'd31) begin
                        if (par ^ bit_val) begin
                            par_fail = 1'b1;
                        end else begin
                            sf_done   = 1'b1;
                            state_n   = PRE;
                            need_g_n  = 1'b1;
                            pre_cnt_n = 2'd0;
                        end
                    end
                end
            end

            default: begin
                state_n = HUNT;
            end
        endcase

        if (err || par_fail) begin
            state_n = HUNT;
            half_n  = 1'b0;
        end
    end

    // ---- stage p3: pairing, output registers and lock tracking ----
    logic [23:0]       hold_data;
    logic              hold_v;
    logic              hold_b;
    logic              hold_vld;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_next;

    assign good_next = sat_inc(good_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data    <= '0;
            hold_v       <= 1'b0;
            hold_b       <= 1'b0;
            hold_vld     <= 1'b0;
            good_cnt     <= '0;
            data_left    <= '0;
            data_right   <= '0;
            validity     <= 1'b0;
            block_start  <= 1'b0;
            sample_valid <= 1'b0;
            parity_error <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            parity_error <= par_fail;
            if (err || par_fail) begin
                hold_vld <= 1'b0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (sf_done) begin
                if (!chan_b) begin
                    // A newer channel A subframe simply replaces any held one.
                    hold_data <= sub[23:0];
                    hold_v    <= sub[24];
                    hold_b    <= blk;
                    hold_vld  <= 1'b1;
                end else if (hold_vld) begin
                    data_left    <= hold_data;
                    data_right   <= sub[23:0];
                    validity     <= hold_v | sub[24];
                    block_start  <= hold_b;
                    sample_valid <= 1'b1;
                    hold_vld     <= 1'b0;
                    good_cnt     <= good_next;
                    locked       <= (good_next >= GOOD_LIM);
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_receive.sv
// ---------------------------------------------------------------------------
// tb_spdif_receive
//
// Directed bench for spdif_receive at CELL_CYCLES = 4, SYNC_FRAMES = 2.
// A biphase-mark line is synthesised from interval lengths (in UI). A monitor
// records every sample_valid pulse, with data, flags and lock state, and
// every parity_error pulse. Each scenario task compares against
// hand-written expected values.
// ---------------------------------------------------------------------------
module tb_spdif_receive;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        spdif_in;
    logic [23:0] data_left;
    logic [23:0] data_right;
    logic        validity;
    logic        block_start;
    logic        sample_valid;
    logic        parity_error;
    logic        locked;

    spdif_receive #(
        .CELL_CYCLES(C),
        .SYNC_FRAMES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spdif_in     (spdif_in),
        .data_left    (data_left),
        .data_right   (data_right),
        .validity     (validity),
        .block_start  (block_start),
        .sample_valid (sample_valid),
        .parity_error (parity_error),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] q_left[$];
    logic [23:0] q_right[$];
    logic        q_v[$];
    logic        q_b[$];
    logic        q_lk[$];
    int          perr_pulses;
    int          perr_cycles;
    int          sv_double;
    logic        perr_lock;
    logic        sv_prev;
    logic        perr_prev;

    bit jit_en;
    int jit_idx;

    always @(negedge clk) begin
        if (rst) begin
            sv_prev   = 1'b0;
            perr_prev = 1'b0;
        end else begin
            if (sample_valid) begin
                q_left.push_back(data_left);
                q_right.push_back(data_right);
                q_v.push_back(validity);
                q_b.push_back(block_start);
                q_lk.push_back(locked);
                if (sv_prev) sv_double++;
            end
            if (parity_error) begin
                perr_cycles++;
                if (!perr_prev) perr_pulses++;
                perr_lock = locked;
            end
            sv_prev   = sample_valid;
            perr_prev = parity_error;
        end
    end

    task automatic clear_mon();
        q_left.delete();
        q_right.delete();
        q_v.delete();
        q_b.delete();
        q_lk.delete();
        perr_pulses = 0;
        perr_cycles = 0;
        sv_double   = 0;
        perr_lock   = 1'b1;
    endtask

    function automatic logic [27:0] mk_word(input logic [23:0] a, input logic v);
        logic [27:0] w;
        w     = {1'b0, 1'b0, 1'b0, v, a};
        w[27] = ^w[26:0];
        return w;
    endfunction

    // Hold the current level for ui half-cells (optionally jittered), then toggle.
    task automatic send_iv(input int ui);
        int n;
        n = ui * C;
        if (jit_en) begin
            n = n + (jit_idx % 3) - 1;
            jit_idx++;
        end
        repeat (n) @(negedge clk);
        spdif_in = ~spdif_in;
    endtask

    task automatic send_slots(input logic [27:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (w[i]) begin
                send_iv(1);
                send_iv(1);
            end else begin
                send_iv(2);
            end
        end
    endtask

    // pre: 0 = B, 1 = M, 2 = W
    task automatic send_pre(input int pre);
        int iv[4];
        case (pre)
            0:       iv = '{3, 1, 1, 3};
            1:       iv = '{3, 3, 1, 1};
            default: iv = '{3, 2, 1, 2};
        endcase
        foreach (iv[i]) send_iv(iv[i]);
    endtask

    task automatic send_frame(input bit first, input logic [23:0] l, input logic [23:0] r,
                              input logic vl, input logic vr, input bit flip);
        logic [27:0] wl;
        logic [27:0] wr;
        wl = mk_word(l, vl);
        wr = mk_word(r, vr);
        if (flip) wr[27] = ~wr[27];
        send_pre(first ? 0 : 1);
        send_slots(wl, 0, 27);
        send_pre(2);
        send_slots(wr, 0, 27);
    endtask

    task automatic start_stream();
        repeat (40) @(negedge clk);
        spdif_in = ~spdif_in;
    endtask

    task automatic idle();
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        spdif_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_left !== 24'h0) begin errors++; $display("FAIL reset_data_left got %h exp %h", data_left, 24'h0); end
        checks++; if (data_right !== 24'h0) begin errors++; $display("FAIL reset_data_right got %h exp %h", data_right, 24'h0); end
        checks++; if (validity !== 1'b0) begin errors++; $display("FAIL reset_validity got %b exp 0", validity); end
        checks++; if (block_start !== 1'b0) begin errors++; $display("FAIL reset_block_start got %b exp 0", block_start); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b exp 0", sample_valid); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error got %b exp 0", parity_error); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Ideal stream (idle level 0) and the same stream with the line inverted.
    task automatic test_clean_stream(input logic idle_level, input string tag);
        clear_mon();
        spdif_in = idle_level;
        start_stream();
        send_frame(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h123456, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h123456, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        idle();
        checks++; if (q_left.size() != 3) begin errors++; $display("FAIL %s_pairs got %0d exp 3", tag, q_left.size()); end
        for (int i = 0; i < 3 && i < q_left.size(); i++) begin
            checks++; if (q_left[i] !== 24'h123456) begin errors++; $display("FAIL %s_left[%0d] got %h exp 123456", tag, i, q_left[i]); end
            checks++; if (q_right[i] !== 24'hABCDEF) begin errors++; $display("FAIL %s_right[%0d] got %h exp abcdef", tag, i, q_right[i]); end
            checks++; if (q_v[i] !== 1'b0) begin errors++; $display("FAIL %s_validity[%0d] got %b exp 0", tag, i, q_v[i]); end
            checks++; if (q_b[i] !== (i == 0)) begin errors++; $display("FAIL %s_block_start[%0d] got %b exp %b", tag, i, q_b[i], (i == 0)); end
            checks++; if (q_lk[i] !== (i != 0)) begin errors++; $display("FAIL %s_locked[%0d] got %b exp %b", tag, i, q_lk[i], (i != 0)); end
        end
        checks++; if (sv_double != 0) begin errors++; $display("FAIL %s_strobe_width got %0d long pulses exp 0", tag, sv_double); end
        checks++; if (perr_pulses != 0) begin errors++; $display("FAIL %s_parity_pulses got %0d exp 0", tag, perr_pulses); end
        checks++; if (data_left !== 24'h123456) begin errors++; $display("FAIL %s_left_hold got %h exp 123456", tag, data_left); end
    endtask

    task automatic test_parity();
        logic [23:0] el[4];
        logic [23:0] er[4];
        logic        ev[4];
        logic        eb[4];
        logic        ek[4];
        el = '{24'h111111, 24'h333333, 24'h777777, 24'h999999};
        er = '{24'h222222, 24'h444444, 24'h888888, 24'hAAAAAA};
        ev = '{1'b0, 1'b1, 1'b0, 1'b0};
        eb = '{1'b1, 1'b0, 1'b0, 1'b0};
        ek = '{1'b0, 1'b1, 1'b0, 1'b1};
        clear_mon();
        start_stream();
        send_frame(1'b1, 24'h111111, 24'h222222, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h333333, 24'h444444, 1'b0, 1'b1, 1'b0);
        send_frame(1'b0, 24'h555555, 24'h666666, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 24'h777777, 24'h888888, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h999999, 24'hAAAAAA, 1'b0, 1'b0, 1'b0);
        idle();
        checks++; if (q_left.size() != 4) begin errors++; $display("FAIL parity_pairs got %0d exp 4", q_left.size()); end
        for (int i = 0; i < 4 && i < q_left.size(); i++) begin
            checks++; if (q_left[i] !== el[i]) begin errors++; $display("FAIL parity_left[%0d] got %h exp %h", i, q_left[i], el[i]); end
            checks++; if (q_right[i] !== er[i]) begin errors++; $display("FAIL parity_right[%0d] got %h exp %h", i, q_right[i], er[i]); end
            checks++; if (q_v[i] !== ev[i]) begin errors++; $display("FAIL parity_validity[%0d] got %b exp %b", i, q_v[i], ev[i]); end
            checks++; if (q_b[i] !== eb[i]) begin errors++; $display("FAIL parity_block_start[%0d] got %b exp %b", i, q_b[i], eb[i]); end
            checks++; if (q_lk[i] !== ek[i]) begin errors++; $display("FAIL parity_locked[%0d] got %b exp %b", i, q_lk[i], ek[i]); end
        end
        checks++; if (perr_pulses != 1) begin errors++; $display("FAIL parity_pulses got %0d exp 1", perr_pulses); end
        checks++; if (perr_cycles != 1) begin errors++; $display("FAIL parity_pulse_width got %0d exp 1", perr_cycles); end
        checks++; if (perr_lock !== 1'b0) begin errors++; $display("FAIL parity_lock_drop got %b exp 0", perr_lock); end
    endtask

    task automatic test_timeout();
        logic [23:0] el[4];
        logic [23:0] er[4];
        logic        ek[4];
        el = '{24'hA1B2C3, 24'h102030, 24'h0A0B0C, 24'h00FF00};
        er = '{24'h0D0E0F, 24'h405060, 24'h5A5A5A, 24'hC3C3C3};
        ek = '{1'b0, 1'b1, 1'b0, 1'b1};
        clear_mon();
        start_stream();
        send_frame(1'b1, 24'hA1B2C3, 24'h0D0E0F, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h102030, 24'h405060, 1'b0, 1'b0, 1'b0);
        send_pre(1);
        send_slots(mk_word(24'hFFFFFF, 1'b0), 0, 9);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_locked_before got %b exp 1", locked); end
        repeat (20) @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked_after got %b exp 0", locked); end
        checks++; if (q_left.size() != 2) begin errors++; $display("FAIL timeout_no_strobe got %0d pairs exp 2", q_left.size()); end
        spdif_in = ~spdif_in;
        send_frame(1'b0, 24'h0A0B0C, 24'h5A5A5A, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h00FF00, 24'hC3C3C3, 1'b0, 1'b0, 1'b0);
        idle();
        checks++; if (q_left.size() != 4) begin errors++; $display("FAIL timeout_pairs got %0d exp 4", q_left.size()); end
        for (int i = 0; i < 4 && i < q_left.size(); i++) begin
            checks++; if (q_left[i] !== el[i]) begin errors++; $display("FAIL timeout_left[%0d] got %h exp %h", i, q_left[i], el[i]); end
            checks++; if (q_right[i] !== er[i]) begin errors++; $display("FAIL timeout_right[%0d] got %h exp %h", i, q_right[i], er[i]); end
            checks++; if (q_lk[i] !== ek[i]) begin errors++; $display("FAIL timeout_locked[%0d] got %b exp %b", i, q_lk[i], ek[i]); end
        end
        checks++; if (perr_pulses != 0) begin errors++; $display("FAIL timeout_parity_pulses got %0d exp 0", perr_pulses); end
    endtask

    task automatic test_jitter();
        logic [23:0] el[3];
        logic [23:0] er[3];
        logic        ev[3];
        logic        eb[3];
        logic        ek[3];
        el = '{24'hC0FFEE, 24'h800001, 24'h5A5A5A};
        er = '{24'h00BEEF, 24'h7FFFFE, 24'hA5A5A5};
        ev = '{1'b1, 1'b0, 1'b1};
        eb = '{1'b1, 1'b0, 1'b0};
        ek = '{1'b0, 1'b1, 1'b1};
        clear_mon();
        start_stream();
        jit_idx = 0;
        jit_en  = 1'b1;
        send_frame(1'b1, 24'hC0FFEE, 24'h00BEEF, 1'b0, 1'b1, 1'b0);
        send_frame(1'b0, 24'h800001, 24'h7FFFFE, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h5A5A5A, 24'hA5A5A5, 1'b1, 1'b0, 1'b0);
        jit_en = 1'b0;
        idle();
        checks++; if (q_left.size() != 3) begin errors++; $display("FAIL jitter_pairs got %0d exp 3", q_left.size()); end
        for (int i = 0; i < 3 && i < q_left.size(); i++) begin
            checks++; if (q_left[i] !== el[i]) begin errors++; $display("FAIL jitter_left[%0d] got %h exp %h", i, q_left[i], el[i]); end
            checks++; if (q_right[i] !== er[i]) begin errors++; $display("FAIL jitter_right[%0d] got %h exp %h", i, q_right[i], er[i]); end
            checks++; if (q_v[i] !== ev[i]) begin errors++; $display("FAIL jitter_validity[%0d] got %b exp %b", i, q_v[i], ev[i]); end
            checks++; if (q_b[i] !== eb[i]) begin errors++; $display("FAIL jitter_block_start[%0d] got %b exp %b", i, q_b[i], eb[i]); end
            checks++; if (q_lk[i] !== ek[i]) begin errors++; $display("FAIL jitter_locked[%0d] got %b exp %b", i, q_lk[i], ek[i]); end
        end
        checks++; if (perr_pulses != 0) begin errors++; $display("FAIL jitter_parity_pulses got %0d exp 0", perr_pulses); end
    endtask

    task automatic test_reset_mid();
        logic [27:0] w3;
        w3 = mk_word(24'h0F0F0F, 1'b0);
        clear_mon();
        start_stream();
        send_frame(1'b1, 24'h010203, 24'h040506, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 24'h070809, 24'h0A0B0C, 1'b0, 1'b0, 1'b0);
        send_pre(1);
        send_slots(w3, 0, 10);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstmid_locked_before got %b exp 1", locked); end
        rst = 1'b1;
        #1;
        checks++; if (data_left !== 24'h0) begin errors++; $display("FAIL rstmid_data_left got %h exp %h", data_left, 24'h0); end
        checks++; if (data_right !== 24'h0) begin errors++; $display("FAIL rstmid_data_right got %h exp %h", data_right, 24'h0); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_locked got %b exp 0", locked); end
        checks++; if ({validity, block_start, sample_valid, parity_error} !== 4'b0) begin
            errors++; $display("FAIL rstmid_flags got %b exp 0000", {validity, block_start, sample_valid, parity_error});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        send_slots(w3, 11, 27);
        send_pre(2);
        send_slots(mk_word(24'h111111, 1'b0), 0, 27);
        send_frame(1'b0, 24'h13579B, 24'h2468AC, 1'b0, 1'b0, 1'b0);
        idle();
        checks++; if (q_left.size() != 1) begin errors++; $display("FAIL rstmid_pairs got %0d exp 1", q_left.size()); end
        if (q_left.size() > 0) begin
            checks++; if (q_left[0] !== 24'h13579B) begin errors++; $display("FAIL rstmid_left got %h exp 13579b", q_left[0]); end
            checks++; if (q_right[0] !== 24'h2468AC) begin errors++; $display("FAIL rstmid_right got %h exp 2468ac", q_right[0]); end
            checks++; if (q_b[0] !== 1'b0) begin errors++; $display("FAIL rstmid_block_start got %b exp 0", q_b[0]); end
            checks++; if (q_lk[0] !== 1'b0) begin errors++; $display("FAIL rstmid_locked_pair got %b exp 0", q_lk[0]); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        spdif_in = 1'b0;
        jit_en   = 1'b0;
        jit_idx  = 0;
        clear_mon();
        test_reset();
        test_clean_stream(1'b0, "ideal");
        test_clean_stream(1'b1, "inverted");
        test_parity();
        test_timeout();
        test_jitter();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
